// File: rtl/sha2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sha2_pkg
// Brief    : Shared SHA-2 message-schedule definitions: round constant tables
//            for SHA-256 (64 x 32) and SHA-512 (80 x 64), sigma rotate/shift
//            amounts, width-selectable sigma0/sigma1 functions, sliding-window
//            index constants and the skid-buffer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sha2_pkg;

    // Window positions (0 = oldest word, w[t-16])
    localparam int IDX_T16 = 0;
    localparam int IDX_T15 = 1;
    localparam int IDX_T7  = 9;
    localparam int IDX_T2  = 14;

    // SHA-256 sigma amounts
    localparam int unsigned S256_S0_R1 = 7;
    localparam int unsigned S256_S0_R2 = 18;
    localparam int unsigned S256_S0_SH = 3;
    localparam int unsigned S256_S1_R1 = 17;
    localparam int unsigned S256_S1_R2 = 19;
    localparam int unsigned S256_S1_SH = 10;
    // SHA-512 sigma amounts
    localparam int unsigned S512_S0_R1 = 1;
    localparam int unsigned S512_S0_R2 = 8;
    localparam int unsigned S512_S0_SH = 7;
    localparam int unsigned S512_S1_R1 = 19;
    localparam int unsigned S512_S1_R2 = 61;
    localparam int unsigned S512_S1_SH = 6;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // All helpers carry words in a 64-bit container; for 32-bit words the
    // upper half is zero and only the low half is meaningful.
    function automatic logic [63:0] sha2_rotr(input logic [63:0] x, input int unsigned n,
                                              input int unsigned word_w);
        logic [63:0] r;
        if (word_w == 32) r = {32'd0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
        else              r = (x >> n) | (x << (64 - n));
        return r;
    endfunction

    function automatic logic [63:0] sha2_shr(input logic [63:0] x, input int unsigned n,
                                             input int unsigned word_w);
        logic [63:0] r;
        if (word_w == 32) r = {32'd0, x[31:0] >> n};
        else              r = x >> n;
        return r;
    endfunction

    function automatic logic [63:0] sha2_sigma0(input logic [63:0] x, input int unsigned word_w);
        logic [63:0] r;
        if (word_w == 32)
            r = sha2_rotr(x, S256_S0_R1, 32) ^ sha2_rotr(x, S256_S0_R2, 32) ^ sha2_shr(x, S256_S0_SH, 32);
        else
            r = sha2_rotr(x, S512_S0_R1, 64) ^ sha2_rotr(x, S512_S0_R2, 64) ^ sha2_shr(x, S512_S0_SH, 64);
        return r;
    endfunction

    function automatic logic [63:0] sha2_sigma1(input logic [63:0] x, input int unsigned word_w);
        logic [63:0] r;
        if (word_w == 32)
            r = sha2_rotr(x, S256_S1_R1, 32) ^ sha2_rotr(x, S256_S1_R2, 32) ^ sha2_shr(x, S256_S1_SH, 32);
        else
            r = sha2_rotr(x, S512_S1_R1, 64) ^ sha2_rotr(x, S512_S1_R2, 64) ^ sha2_shr(x, S512_S1_SH, 64);
        return r;
    endfunction

    function automatic logic [63:0] sha2_k(input int round, input int word_w);
        logic [63:0] r;
        if (word_w == 32) r = {32'd0, K256[6'(round)]};
        else              r = K512[7'(round)];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha2_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : sha2_skid_buf
// Brief    : Generic 2-entry valid/ready skid buffer. A main register drives
//            the outputs; a skid register absorbs the one entry that can
//            arrive while downstream stalls, so in_ready can be registered
//            without losing throughput.
// Ports    : clk, rst_n (async, active low), flush (sync clear of entries)
//            in_valid/in_ready/in_data   - upstream side
//            out_valid/out_ready/out_data - downstream side
// Revision : 1.0 - initial release
// ============================================================================
module sha2_skid_buf
    import sha2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_e       r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main;
    logic w_load_skid;
    logic w_skid_to_main;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    assign w_load_main    = w_in_fire & ((r_state == SKID_EMPTY) | ((r_state == SKID_ONE) & w_out_fire));
    assign w_load_skid    = w_in_fire & (r_state == SKID_ONE) & ~w_out_fire;
    assign w_skid_to_main = w_out_fire & (r_state == SKID_FULL);

    // Control state: only the valid/ready view is reset or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= SKID_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_in_fire && !w_out_fire) begin
                        r_state    <= SKID_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_in_fire && w_out_fire) begin
                        r_state     <= SKID_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                SKID_FULL: begin
                    if (w_out_fire) begin
                        r_state    <= SKID_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload registers carry no reset; contents are ignored while invalid.
    always_ff @(posedge clk) begin
        if (w_load_main)         r_main <= in_data;
        else if (w_skid_to_main) r_main <= r_skid;
        if (w_load_skid)         r_skid <= in_data;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

endmodule
`default_nettype wire

// File: rtl/sha2_w_expand_stage.sv
`default_nettype none
// ============================================================================
// Module   : sha2_w_expand_stage
// Brief    : One handshaked SHA-2 message-schedule stage. Computes
//            W_t = sigma1(w[t-2]) + w[t-7] + sigma0(w[t-15]) + w[t-16]
//            from a 16-word window, slides the window by one word and
//            buffers the result in a 2-entry skid buffer.
// Ports    : clk, rst_n (async, active low), flush
//            in_valid/in_ready/in_win/in_tag
//            out_valid/out_ready/out_win/out_wt/out_tag (+out_wk)
// Config   : SHA2_W_PRECOMP_KW_EN adds out_wk = W_t + K[ROUND].
// Revision : 1.0 - initial release
// ============================================================================
module sha2_w_expand_stage
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROUND  = 16,
    parameter int TAG_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*WORD_W-1:0] in_win,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*WORD_W-1:0] out_win,
    output logic [WORD_W-1:0]    out_wt,
    output logic [TAG_W-1:0]     out_tag
`ifdef SHA2_W_PRECOMP_KW_EN
    ,
    output logic [WORD_W-1:0]    out_wk
`endif
);

    localparam int c_win_w = 16 * WORD_W;
`ifdef SHA2_W_PRECOMP_KW_EN
    localparam int c_tag_lsb = WORD_W;
`else
    localparam int c_tag_lsb = 0;
`endif
    localparam int c_wt_lsb  = c_tag_lsb + TAG_W;
    localparam int c_win_lsb = c_wt_lsb + WORD_W;
    localparam int c_data_w  = c_win_lsb + c_win_w;

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("sha2_w_expand_stage: WORD_W must be 32 or 64");
        end
        if (ROUND < 16 || ROUND > ((WORD_W == 64) ? 79 : 63)) begin : g_bad_round
            $error("sha2_w_expand_stage: ROUND out of range for WORD_W");
        end
    endgenerate

    logic [WORD_W-1:0] w_t16;
    logic [WORD_W-1:0] w_t15;
    logic [WORD_W-1:0] w_t7;
    logic [WORD_W-1:0] w_t2;
    logic [63:0]       w_s0_full;
    logic [63:0]       w_s1_full;
    logic [WORD_W-1:0] w_wt;
    logic [c_data_w-1:0] w_in_data;
    logic [c_data_w-1:0] w_out_data;

    // Word i sits at bit offset (15-i)*WORD_W since the oldest word is the MSB.
    assign w_t16 = in_win[(15 - IDX_T16) * WORD_W +: WORD_W];
    assign w_t15 = in_win[(15 - IDX_T15) * WORD_W +: WORD_W];
    assign w_t7  = in_win[(15 - IDX_T7)  * WORD_W +: WORD_W];
    assign w_t2  = in_win[(15 - IDX_T2)  * WORD_W +: WORD_W];

    assign w_s0_full = sha2_sigma0(64'(w_t15), WORD_W);
    assign w_s1_full = sha2_sigma1(64'(w_t2), WORD_W);

    generate
        if (WORD_W == 32) begin : g_trim_hi
            // Upper container halves are always zero for 32-bit words.
            logic w_unused_hi;
            assign w_unused_hi = ^{w_s0_full[63:32], w_s1_full[63:32]};
        end
    endgenerate

    assign w_wt = w_s1_full[WORD_W-1:0] + w_t7 + w_s0_full[WORD_W-1:0] + w_t16;

`ifdef SHA2_W_PRECOMP_KW_EN
    localparam logic [63:0] c_k_full = sha2_k(ROUND, WORD_W);
    logic [WORD_W-1:0] w_wk;
    assign w_wk      = w_wt + c_k_full[WORD_W-1:0];
    assign w_in_data = {in_win[c_win_w-WORD_W-1:0], w_wt, w_wt, in_tag, w_wk};
`else
    assign w_in_data = {in_win[c_win_w-WORD_W-1:0], w_wt, w_wt, in_tag};
`endif

    sha2_skid_buf #(
        .DATA_W (c_data_w)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign out_win = w_out_data[c_win_lsb +: c_win_w];
    assign out_wt  = w_out_data[c_wt_lsb  +: WORD_W];
    assign out_tag = w_out_data[c_tag_lsb +: TAG_W];
`ifdef SHA2_W_PRECOMP_KW_EN
    assign out_wk  = w_out_data[0 +: WORD_W];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha2_w_expand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_w_expand_stage
// Brief    : Scoreboard bench for sha2_w_expand_stage. A SHA-256 instance
//            (ROUND=16) and a SHA-512 instance (ROUND=17) share handshake
//            controls; expected entries are queued on acceptance and a
//            separate monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_w_expand_stage;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [511:0]  in_win32  = '0;
    logic [1023:0] in_win64  = '0;
    logic [7:0]    in_tag    = '0;

    logic          in_ready32, out_valid32, in_ready64, out_valid64;
    logic [511:0]  out_win32;
    logic [1023:0] out_win64;
    logic [31:0]   out_wt32;
    logic [63:0]   out_wt64;
    logic [7:0]    out_tag32, out_tag64;
`ifdef SHA2_W_PRECOMP_KW_EN
    logic [31:0]   out_wk32;
    logic [63:0]   out_wk64;
`endif

    always #5 clk = ~clk;

    sha2_w_expand_stage #(.WORD_W(32), .ROUND(16), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_win(in_win32), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_win(out_win32),
        .out_wt(out_wt32), .out_tag(out_tag32)
`ifdef SHA2_W_PRECOMP_KW_EN
        , .out_wk(out_wk32)
`endif
    );

    sha2_w_expand_stage #(.WORD_W(64), .ROUND(17), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_win(in_win64), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_win(out_win64),
        .out_wt(out_wt64), .out_tag(out_tag64)
`ifdef SHA2_W_PRECOMP_KW_EN
        , .out_wk(out_wk64)
`endif
    );

    typedef struct {
        logic [7:0]    tag;
        logic [511:0]  win32;
        logic [31:0]   wt32;
        logic [1023:0] win64;
        logic [63:0]   wt64;
        logic [31:0]   wk32;
        logic [63:0]   wk64;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [31:0] ref_w32(input logic [511:0] win);
        logic [31:0] w [16];
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = win[511 - 32*i -: 32];
        s0 = ror32(w[1], 7) ^ ror32(w[1], 18) ^ (w[1] >> 3);
        s1 = ror32(w[14], 17) ^ ror32(w[14], 19) ^ (w[14] >> 10);
        return s1 + w[9] + s0 + w[0];
    endfunction

    function automatic logic [63:0] ref_w64(input logic [1023:0] win);
        logic [63:0] w [16];
        logic [63:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = win[1023 - 64*i -: 64];
        s0 = ror64(w[1], 1) ^ ror64(w[1], 8) ^ (w[1] >> 7);
        s1 = ror64(w[14], 19) ^ ror64(w[14], 61) ^ (w[14] >> 6);
        return s1 + w[9] + s0 + w[0];
    endfunction

    function automatic logic [511:0] rand_win32();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [1023:0] rand_win64();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit v, input logic [511:0] w32, input logic [1023:0] w64,
                        input logic [7:0] tag, input bit ordy, input bit fl);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_win32  = w32;
        in_win64  = w64;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            exp_q.delete();
        end else if (v && in_ready32) begin
            e.tag   = tag;
            e.wt32  = ref_w32(w32);
            e.win32 = {w32[479:0], e.wt32};
            e.wt64  = ref_w64(w64);
            e.win64 = {w64[959:0], e.wt64};
            e.wk32  = e.wt32 + 32'he49b69c1;
            e.wk64  = e.wt64 + 64'hefbe4786384f25e3;
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !flush) begin
                if (out_valid32 && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: tag %0h appeared, none expected", out_tag32);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("tag32", out_tag32, e.tag);
                        check("wt32", out_wt32, e.wt32);
                        check("win32", out_win32, e.win32);
                        check("valid64", out_valid64, 1'b1);
                        check("tag64", out_tag64, e.tag);
                        check("wt64", out_wt64, e.wt64);
                        check("win64_hi", out_win64[1023:512], e.win64[1023:512]);
                        check("win64_lo", out_win64[511:0], e.win64[511:0]);
`ifdef SHA2_W_PRECOMP_KW_EN
                        check("wk32", out_wk32, e.wk32);
                        check("wk64", out_wk64, e.wk64);
`endif
                    end
                end else if (out_valid64 && out_ready) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output64: tag %0h appeared, none expected", out_tag64);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [511:0]  abc32_r16, abc32_r17, rw32, hold32;
    logic [1023:0] abc64_r17, rw64, hold64;

    initial begin
        abc32_r16 = {32'h61626380, {14{32'h0}}, 32'h00000018};
        abc32_r17 = {{14{32'h0}}, 32'h00000018, 32'h61626380};
        abc64_r17 = {{14{64'h0}}, 64'h18, 64'h6162638000000000};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid32", out_valid32, 1'b0);
        check("rst_in_ready32", in_ready32, 1'b1);
        check("rst_out_valid64", out_valid64, 1'b0);
        check("rst_in_ready64", in_ready64, 1'b1);
        rst_n = 1'b1;

        // known-answer vectors, back to back
        step(1, abc32_r16, abc64_r17, 8'hA1, 1, 0);
        step(1, abc32_r17, abc64_r17, 8'hA2, 1, 0);
        #1;
        check("abc_latency_valid", out_valid32, 1'b1);
        check("abc256_r16_wt", out_wt32, 32'h61626380);
        check("abc512_r17_wt", out_wt64, 64'h00030000000000C0);
`ifdef SHA2_W_PRECOMP_KW_EN
        check("abc256_r16_wk", out_wk32, 32'h45FDCD41);
        check("abc512_r17_wk", out_wk64, 64'hefc14786384f26a3);
`endif
        step(0, '0, '0, 8'h00, 1, 0);
        #1;
        check("abc256_r17_wt", out_wt32, 32'h000F0000);
        check("abc256_r17_win_lsb", out_win32[31:0], 32'h000F0000);
        step(0, '0, '0, 8'h00, 1, 0);

        // backpressure: tags 1,2,3 with out_ready low
        step(1, rand_win32(), rand_win64(), 8'd1, 0, 0);
        step(1, rand_win32(), rand_win64(), 8'd2, 0, 0);
        hold32 = rand_win32();
        hold64 = rand_win64();
        step(1, hold32, hold64, 8'd3, 0, 0);
        #1;
        check("bp_in_ready_full", in_ready32, 1'b0);
        step(1, hold32, hold64, 8'd3, 1, 0);
        #1;
        check("bp_no_gap_1", out_valid32, 1'b1);
        step(1, hold32, hold64, 8'd3, 1, 0);
        #1;
        check("bp_no_gap_2", out_valid32, 1'b1);
        step(0, '0, '0, 8'h00, 1, 0);
        #1;
        check("bp_no_gap_3", out_valid32, 1'b1);
        step(0, '0, '0, 8'h00, 1, 0);
        #1;
        check("bp_drained", out_valid32, 1'b0);

        // flush while full
        step(1, rand_win32(), rand_win64(), 8'd10, 0, 0);
        step(1, rand_win32(), rand_win64(), 8'd11, 0, 0);
        step(1, rand_win32(), rand_win64(), 8'd12, 0, 1);
        #1;
        check("flush_was_full", in_ready32, 1'b0);
        step(0, '0, '0, 8'h00, 1, 0);
        #1;
        check("flush_out_valid", out_valid32, 1'b0);
        check("flush_in_ready", in_ready32, 1'b1);
        step(0, '0, '0, 8'h00, 1, 0);

        // asynchronous reset while full
        step(1, rand_win32(), rand_win64(), 8'd20, 0, 0);
        step(1, rand_win32(), rand_win64(), 8'd21, 0, 0);
        step(0, '0, '0, 8'h00, 0, 0);
        #1;
        check("arst_was_full", in_ready32, 1'b0);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid32", out_valid32, 1'b0);
        check("arst_in_ready32", in_ready32, 1'b1);
        check("arst_out_valid64", out_valid64, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, rand_win32(), rand_win64(), 8'd22, 1, 0);
        step(0, '0, '0, 8'h00, 1, 0);
        #1;
        check("arst_next_entry", out_valid32, 1'b1);
        step(0, '0, '0, 8'h00, 1, 0);
        #1;
        check("arst_entry_alone", out_valid32, 1'b0);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rw32 = rand_win32();
            rw64 = rand_win64();
            step($urandom_range(0, 3) != 0, rw32, rw64, 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end

        // bounded drain
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            step(0, '0, '0, 8'h00, 1, 0);
        end
        #3;
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (3) step(0, '0, '0, 8'h00, 1, 0);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha2_w_expand_stage.md
# sha2_w_expand_stage

- Parametrised, handshaked pipeline stage of the SHA-2 message schedule. It takes a 16-word sliding window and produces the next schedule word W_t for a fixed round t, for either SHA-256 (32-bit words) or SHA-512 (64-bit words).
- Instances are chained, one per round t = 16..63 (or 16..79), between the block loader and the compression pipeline.
- Valid/ready backpressure replaces the free-running write-enable register of earlier expanders. A 2-entry skid buffer keeps the stage at full throughput with a registered in_ready.

## Interface
- WORD_W, 32: word width; 32 selects SHA-256 sigma functions, 64 selects SHA-512; any other value is an elaboration error.
- ROUND, 16: round index t of the produced word; legal range 16..63 (WORD_W=32) or 16..79 (WORD_W=64); out of range is an elaboration error.
- TAG_W, 8: width of the sideband tag (job/nonce id) carried alongside the window.
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  input window valid.
- in_ready  out  1  stage can accept; registered.
- in_win  in  16*WORD_W  window {w[t-16] (MSBs), w[t-15], ..., w[t-1] (LSBs)}.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_win  out  16*WORD_W  {w[t-15], ..., w[t-1], W_t}.
- out_wt  out  WORD_W  W_t, duplicate of the out_win LSB word.
- out_tag  out  TAG_W  tag of the output entry.
- out_wk  out  WORD_W  W_t + K_t, present only with SHA2_W_PRECOMP_KW_EN.

## Operation
- Window index i=0 is the oldest word (w[t-16]).
- W_t = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^WORD_W. All carries are discarded.
- SHA-256 sigma functions:
  - sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  - sigma1 = ROTR17 ^ ROTR19 ^ SHR10
- SHA-512 sigma functions:
  - sigma0 = ROTR1 ^ ROTR8 ^ SHR7
  - sigma1 = ROTR19 ^ ROTR61 ^ SHR6
- Output window = input window shifted one word toward the MSB, with W_t appended at the LSB. Window and tag pass through unmodified otherwise.
- Storage is a main register (drives the outputs) plus a skid register. States:
  - EMPTY: main and skid both invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid both valid.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. Transfers are in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
- Transitions:
  - EMPTY, in_fire: load main -> ONE.
  - ONE, in_fire with out_fire: reload main -> ONE.
  - ONE, in_fire without out_fire: load skid -> FULL.
  - ONE, out_fire only -> EMPTY.
  - FULL, out_fire: skid moves to main -> ONE.
  - Otherwise the state holds.
- W_t is computed combinationally on in_win and captured with the entry. The skid register stores the computed result, so no recompute happens on the skid-to-main move.
- Entries leave in arrival order. No entry is duplicated or dropped while out_ready is deasserted.
- flush has priority over all transfers: next state is EMPTY, and in_fire and out_fire that cycle are ignored.
- Only valid bits are reset or flushed. Data registers are not reset and are don't-care while invalid.

## Timing
- Latency: 1 cycle from in_fire to out_valid.
- Throughput: 1 entry/cycle while out_ready=1.
- Reset values: out_valid=0 and in_ready=1. out_win, out_wt, out_tag and out_wk are undefined but stable until the first load.
- RST assertion mid-operation clears all entries immediately, without waiting for a clock edge.
- The first in_fire is possible on the first rising edge after RST deasserts.
- out_valid must not depend combinationally on out_ready. in_ready is a register output.
- Critical path: sigma computation plus a 4-operand adder, or 5 operands with the precompute feature. Carry-save reduction is permitted.

## Configuration
- SHA2_W_PRECOMP_KW_EN, when defined:
  - Adds port out_wk = W_t + K[ROUND] mod 2^WORD_W, registered and buffered with the entry.
  - Lets the compression stage consume the pre-added term.
- Undefined: out_wk is absent and the K table is not referenced.

## Structure
- Package sha2_pkg holds:
  - SHA-256 K table (64 × 32) and SHA-512 K table (80 × 64).
  - Sigma rotate/shift amount constants per width.
  - sigma0/sigma1 functions parametrised by WORD_W.
  - Window index constants (IDX_T16=0, IDX_T15=1, IDX_T7=9, IDX_T2=14).
- Sub-module sha2_skid_buf: generic 2-entry valid/ready skid buffer of parametrised data width, instantiated with data width 16*WORD_W + WORD_W + TAG_W (+WORD_W with the precompute feature).

## Test plan
- SHA-256 "abc" case, WORD_W=32, ROUND=16:
  - Stimulus: window W0=0x61626380, W1..W14=0, W15=0x00000018.
  - Response: out_wt=0x61626380 one cycle after in_fire.
  - With SHA2_W_PRECOMP_KW_EN: out_wk=0x45FDCD41.
- Same message at ROUND=17:
  - Stimulus: window W1..W16.
  - Response: out_wt=0x000F0000, and out_win LSB word equals out_wt.
- SHA-512 "abc" case, WORD_W=64, ROUND=17:
  - Stimulus: W15=0x18, W1..W14=0, W16=0x6162638000000000.
  - Response: out_wt=0x00030000000000C0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while in_valid=1 with tags 1, 2, 3.
  - Response: in_ready drops after two accepts. Release of out_ready yields tags 1, 2, then 3 in order, with no gaps at out_ready=1.
- Flush with skid buffer full:
  - Stimulus: flush=1 while in_valid=1 in FULL.
  - Response: next cycle out_valid=0 and in_ready=1; the flush-cycle input is not captured.
- Asynchronous reset in FULL:
  - Stimulus: assert RST low between clock edges.
  - Response: out_valid=0 immediately, in_ready=1; the next accepted entry appears alone.
